fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DTYPE (type), default int: payload type, matching the upstream sync FIFO element type.
REQ-002 Parameter PKT_LEN (int), default 8: beats per packet, legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  enables reading; low requests a graceful drain.
REQ-006 fifo_empty  input  1  empty flag from the upstream sync FIFO.
REQ-007 fifo_dout  input  DTYPE  FIFO read data, valid the cycle after an accepted read.
REQ-008 fifo_rreq  output  1  FIFO read request.
REQ-009 m_valid  output  1  output beat valid.
REQ-010 m_ready  input  1  downstream accepts the beat.
REQ-011 m_data  output  DTYPE  output payload.
REQ-012 m_last  output  1  marks the final beat of a PKT_LEN packet.
REQ-013 busy  output  1  high in RUN or DRAIN.
REQ-014 beat_total  output  16  count of accepted output beats, wraps at 2^16.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DRAIN.
- IDLE->RUN when en=1.
- RUN->DRAIN when en=0.
- DRAIN->RUN when en=1.
- DRAIN->IDLE when no read is in flight, the buffer is empty and en=0.
REQ-016 A read is accepted at an edge where fifo_rreq=1 and fifo_empty=0; the block SHALL set a 1-bit inflight flag on that edge.
REQ-017 The block SHALL hold a 2-entry skid buffer with occupancy occ in 0..2; credit = occ + inflight.
REQ-018 fifo_rreq SHALL be combinational and equal to (state==RUN) & !fifo_empty & (credit<2 | (credit==2 & m_valid & m_ready)).
REQ-019 With inflight=1, the block SHALL write fifo_dout into the buffer tail on the next edge; it SHALL never capture fifo_dout when inflight=0.
REQ-020 Simultaneous push and pop SHALL leave occ unchanged and preserve FIFO order.
REQ-021 m_valid SHALL equal (occ!=0), and m_data SHALL be the buffer head.
REQ-022 The first beat SHALL appear on m_valid two edges after the accepting edge; sustained throughput SHALL be 1 beat/cycle when the FIFO is non-empty and m_ready=1.
REQ-023 m_data and m_valid SHALL hold stable while m_valid=1 & m_ready=0.
REQ-024 A packet counter pkt_cnt SHALL run 0..PKT_LEN-1, incrementing on m_valid & m_ready and wrapping to 0 after PKT_LEN-1.
REQ-025 m_last SHALL equal m_valid & (pkt_cnt==PKT_LEN-1); with PKT_LEN=1, every beat is last.
REQ-026 beat_total SHALL increment by 1 per accepted beat, modulo 2^16.
REQ-027 In DRAIN, the block SHALL issue no reads, SHALL still capture an in-flight beat, and SHALL deliver all buffered beats.
REQ-028 Overflow is impossible by construction; an assertion SHALL flag occ>2 or a capture into a full buffer.

Reset
REQ-029 rstn=0 SHALL immediately, independent of clk, force the following:
- state IDLE, occ 0, inflight 0, pkt_cnt 0, beat_total 0.
- m_valid 0, m_last 0, fifo_rreq 0, busy 0, m_data all-zero.
REQ-030 Reset asserted mid-packet SHALL discard buffered and in-flight data; after release, pkt_cnt restarts at 0.
REQ-031 Release SHALL take effect on the first rising edge with rstn=1; no reads are issued before that edge.

Structure
REQ-032 The state enum (IDLE/RUN/DRAIN) and the BEAT_TOTAL_W=16 constant SHALL live in the shared project package.
REQ-033 The 2-entry skid buffer SHALL be a sub-module, skid_buf2, parameterised by DTYPE, with push/pop/occ ports.

Verification
REQ-034 The bench SHALL cover these directed scenarios (PKT_LEN=4, DTYPE=logic[7:0]):
- FIFO preloaded with 0x11..0x18, en=1, m_ready=1 -> m_data 0x11..0x18 on consecutive cycles, first m_valid two edges after the first read; m_last on 0x14 and 0x18; beat_total=8.
- Same preload with m_ready=0 for 6 cycles -> exactly 2 reads accepted, fifo_rreq=0 thereafter; on m_ready=1, 0x11..0x18 arrive in order with no loss or duplicate.
- en dropped the cycle after a read accept -> state DRAIN, in-flight and buffered beats delivered, then IDLE and busy=0; FIFO keeps the remaining entries.
- FIFO fed 1 word every 3 cycles -> no stale fifo_dout captured; output sequence equals input sequence.
- rstn pulsed low with 2 beats buffered at pkt_cnt=2 -> m_valid=0 within the reset pulse without a clock edge; after release the next packet's m_last falls on its 4th beat.
- Run 65537 beats -> beat_total wraps to 1.

Source files
------------

// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader.
package fifo_stream_reader_pkg;
  localparam int BEAT_TOTAL_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;
endpackage

// File: rtl/skid_buf2.sv
// Two-entry in-order skid buffer; entry 0 is always the head.
module skid_buf2 #(
  parameter type DTYPE = int
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push,
  input  DTYPE       push_data,
  input  logic       pop,
  output DTYPE       head,
  output logic [1:0] occ
);
  DTYPE mem0, mem1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ  <= 2'd0;
      mem0 <= '0;
      mem1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) mem0 <= push_data;
          else             mem1 <= push_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          mem0 <= mem1;
          occ  <= occ - 2'd1;
        end
        // Pop and push together: head advances, new beat lands behind it.
        2'b11: begin
          if (occ == 2'd1) mem0 <= push_data;
          else begin
            mem0 <= mem1;
            mem1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = mem0;

  a_occ_range:  assert property (@(posedge clk) disable iff (!rstn) occ <= 2'd2);
  a_no_ovf:     assert property (@(posedge clk) disable iff (!rstn) !(push && !pop && occ == 2'd2));
  a_no_undflow: assert property (@(posedge clk) disable iff (!rstn) !(pop && occ == 2'd0));
endmodule

// File: rtl/fifo_stream_reader.sv
// Pulls words from a sync FIFO (1-cycle read latency) and streams them out
// as valid/ready beats, with packet framing and a running beat count.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter type DTYPE   = int,
  parameter int  PKT_LEN = 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en,
  input  logic                    fifo_empty,
  input  DTYPE                    fifo_dout,
  output logic                    fifo_rreq,
  output logic                    m_valid,
  input  logic                    m_ready,
  output DTYPE                    m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic [BEAT_TOTAL_W-1:0] beat_total
);
  localparam int              CNT_W   = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] PKT_MAX = CNT_W'(PKT_LEN - 1);

  rd_state_e        state;
  logic             inflight;
  logic [1:0]       occ;
  logic [2:0]       credit;
  logic             pop;
  logic [CNT_W-1:0] pkt_cnt;

  // Credit counts buffered plus requested beats so a read is only issued
  // when its data is guaranteed a slot one cycle later.
  assign credit    = {1'b0, occ} + {2'b00, inflight};
  assign pop       = m_valid & m_ready;
  assign fifo_rreq = (state == RUN) & !fifo_empty &
                     ((credit < 3'd2) | ((credit == 3'd2) & pop));
  assign m_valid   = (occ != 2'd0);
  assign m_last    = m_valid & (pkt_cnt == PKT_MAX);
  assign busy      = (state != IDLE);

  skid_buf2 #(.DTYPE(DTYPE)) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .push      (inflight),
    .push_data (fifo_dout),
    .pop       (pop),
    .head      (m_data),
    .occ       (occ)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rreq;
      case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= DRAIN;
        DRAIN: begin
          if (en)                             state <= RUN;
          else if (!inflight && occ == 2'd0)  state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt    <= '0;
      beat_total <= '0;
    end else if (pop) begin
      pkt_cnt    <= (pkt_cnt == PKT_MAX) ? '0 : pkt_cnt + CNT_W'(1);
      beat_total <= beat_total + BEAT_TOTAL_W'(1);
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised + directed bench: FIFO model feeds the reader, a scoreboard of
// words leaving the FIFO is checked by an independent output monitor.
module tb_fifo_stream_reader;
  localparam int PKT_LEN = 4;
  typedef logic [7:0] data_t;
  typedef struct { data_t d; logic l; } exp_t;

  logic        clk, rstn, en, fifo_empty, fifo_rreq;
  data_t       fifo_dout, m_data;
  logic        m_valid, m_ready, m_last, busy;
  logic [15:0] beat_total;

  fifo_stream_reader #(.DTYPE(data_t), .PKT_LEN(PKT_LEN)) dut (
    .clk(clk), .rstn(rstn), .en(en), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rreq(fifo_rreq), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy),
    .beat_total(beat_total)
  );

  initial begin clk = 1'b0; forever #5 clk = ~clk; end

  int    n_cmp = 0, n_err = 0;
  data_t fq[$];
  exp_t  exp_q[$];
  int    ref_idx = 0, rd_cnt = 0, ncyc = 0, first_acc = -1, first_vld = -1;
  int    n_seen = 0, exp_total = 0;
  bit    last_acc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample the read handshake, then model the FIFO's registered
  // read port. Non-read cycles put garbage on fifo_dout.
  task automatic cyc();
    bit    acc;
    data_t d;
    @(negedge clk);
    acc = rstn && fifo_rreq && !fifo_empty;
    if (m_valid && first_vld < 0) first_vld = ncyc;
    if (acc && first_acc < 0)     first_acc = ncyc;
    @(posedge clk); #1;
    ncyc++;
    last_acc = acc;
    if (acc) begin
      d = fq.pop_front();
      fifo_dout = d;
      exp_q.push_back('{d, (ref_idx % PKT_LEN) == PKT_LEN - 1});
      ref_idx++;
      rd_cnt++;
    end else fifo_dout = 8'($urandom);
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic push_word(input data_t d);
    fq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("rst_m_valid", {31'b0, m_valid}, 0);
    chk("rst_m_last", {31'b0, m_last}, 0);
    chk("rst_rreq", {31'b0, fifo_rreq}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_m_data", {24'b0, m_data}, 0);
    chk("rst_beat_total", {16'b0, beat_total}, 0);
    fq.delete(); exp_q.delete();
    ref_idx = 0; rd_cnt = 0;
    en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rstn = 1'b1;
  endtask

  task automatic flush(input string name, input int budget);
    int b = 0;
    while ((fq.size() != 0 || exp_q.size() != 0) && b < budget) begin cyc(); b++; end
    chk({name, "_exp_left"}, exp_q.size(), 0);
    chk({name, "_fifo_left"}, fq.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every accepted beat.
  initial begin
    bit    stall = 0;
    data_t hold_d = '0;
    exp_t  e;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        exp_total = 0; n_seen = 0; stall = 0;
      end else begin
        if (stall) begin
          chk("hold_valid", {31'b0, m_valid}, 1);
          chk("hold_data", {24'b0, m_data}, {24'b0, hold_d});
        end
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) chk("spurious_beat", {31'b0, m_valid}, 0);
          else begin
            e = exp_q.pop_front();
            chk("data", {24'b0, m_data}, {24'b0, e.d});
            chk("last", {31'b0, m_last}, {31'b0, e.l});
            chk("beat_total", {16'b0, beat_total}, exp_total & 32'hFFFF);
          end
          exp_total++; n_seen++;
        end
        stall  = m_valid && !m_ready;
        hold_d = m_data;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int b;
    rstn = 1'b0; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_dout = '0;
    #3;
    do_reset();

    // Streaming at full rate with framing and latency.
    for (int i = 0; i < 8; i++) push_word(data_t'(8'h11 + i));
    m_ready = 1'b1; en = 1'b1; ncyc = 0; first_acc = -1; first_vld = -1;
    for (int i = 0; i < 14; i++) cyc();
    chk("first_latency", first_vld - first_acc, 2);
    chk("s1_beats", n_seen, 8);
    chk("s1_beat_total", {16'b0, beat_total}, 8);
    flush("s1", 4);
    en = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("s1_idle_busy", {31'b0, busy}, 0);

    // Backpressure: only two reads may be outstanding.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(data_t'(8'h11 + i));
    en = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    chk("stall_reads", rd_cnt, 2);
    chk("stall_rreq", {31'b0, fifo_rreq}, 0);
    m_ready = 1'b1;
    flush("s2", 20);
    chk("s2_beats", n_seen, 8);

    // Graceful drain right after a read is accepted.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(data_t'(8'h31 + i));
    m_ready = 1'b1; en = 1'b1;
    b = 0;
    while (!last_acc && b < 10) begin cyc(); b++; end
    chk("drain_saw_accept", {31'b0, last_acc}, 1);
    en = 1'b0;
    cyc();
    chk("drain_busy", {31'b0, busy}, 1);
    chk("drain_rreq", {31'b0, fifo_rreq}, 0);
    for (int i = 0; i < 6; i++) cyc();
    chk("drain_idle_busy", {31'b0, busy}, 0);
    chk("drain_exp_left", exp_q.size(), 0);
    chk("drain_fifo_kept", fq.size(), 6);
    chk("drain_beats", n_seen, rd_cnt);

    // Trickle feed: one word every third cycle, stale fifo_dout is garbage.
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_word(data_t'(8'h51 + i));
      cyc(); cyc(); cyc();
    end
    flush("trickle", 10);
    chk("trickle_beats", n_seen, 8);

    // Reset mid-packet with two beats buffered.
    do_reset();
    for (int i = 0; i < 8; i++) push_word(data_t'(8'h21 + i));
    en = 1'b1; m_ready = 1'b1;
    b = 0;
    while (n_seen < 2 && b < 20) begin cyc(); b++; end
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    chk("pre_rst_valid", {31'b0, m_valid}, 1);
    chk("pre_rst_beats", n_seen, 2);
    do_reset();
    for (int i = 0; i < 4; i++) push_word(data_t'(8'hA1 + i));
    en = 1'b1; m_ready = 1'b1;
    flush("post_rst", 20);
    chk("post_rst_beats", n_seen, 4);

    // Randomised traffic, enable and backpressure.
    do_reset();
    for (int i = 0; i < 500; i++) begin
      cyc();
      en      = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 1) == 1) push_word(8'($urandom));
    end
    en = 1'b1; m_ready = 1'b1;
    flush("rand", 300);
    chk("rand_total", {16'b0, beat_total}, n_seen & 32'hFFFF);

    // beat_total wraps modulo 2^16.
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    b = 0;
    while (n_seen < 65537 && b < 70000) begin
      if (ref_idx + fq.size() < 65537 && fq.size() < 3) push_word(8'($urandom));
      cyc();
      b++;
    end
    cyc();
    chk("wrap_beats", n_seen, 65537);
    chk("wrap_total", {16'b0, beat_total}, 1);
    chk("wrap_exp_left", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
